control_unit: RTL

Multi-cycle sequencer that sits directly upstream of the data path: it fetches 32-bit instruction words over a ready/request handshake, decodes them, and drives the data path's register selectors, write-source selector, write enable, ALU opcode and both immediate operands. It also issues data-memory read requests for loads and stalls until the memory responds. One instruction completes before the next fetch begins. There is no pipelining.

---
 rtl/control_defines.sv | 41 ++++
 rtl/instruction_decoder.sv | 65 ++++++
 rtl/control_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/control_defines.sv
// Shared constants for the instruction sequencer: opcodes, field positions,
// write-source encodings and the sequencer state enumeration.
package control_defines;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ALU  = 4'h1;
    localparam logic [3:0] OPC_LDI  = 4'h2;
    localparam logic [3:0] OPC_LDIH = 4'h3;
    localparam logic [3:0] OPC_LOAD = 4'h4;
    localparam logic [3:0] OPC_JMP  = 4'h5;
    localparam logic [3:0] OPC_HALT = 4'hF;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 26;
    localparam int RS1_MSB = 25;
    localparam int RS1_LSB = 24;
    localparam int RS2_MSB = 23;
    localparam int RS2_LSB = 22;
    localparam int IMM_MSB = 21;
    localparam int IMM_LSB = 0;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_IMM1 = 2'b01;
    localparam logic [1:0] SRC_IMM2 = 2'b10;
    localparam logic [1:0] SRC_MEM  = 2'b11;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_MEMORY_WAIT,
        ST_HALTED
    } state_t;

endpackage

// File: rtl/instruction_decoder.sv
// Purely combinational decode of the latched instruction word into data-path
// selectors, immediates and the control flags the sequencer branches on.
module instruction_decoder
    import control_defines::*;
(
    input  logic [31:0] ir_i,
    output logic [1:0]  rd_o,
    output logic [1:0]  rs1_o,
    output logic [1:0]  rs2_o,
    output logic [1:0]  alu_opcode_o,
    output logic [1:0]  source_o,
    output logic [31:0] imm1_o,
    output logic [31:0] imm2_o,
    output logic        write_o,
    output logic        load_o,
    output logic        jump_o,
    output logic        halt_o,
    output logic        illegal_o
);

    logic [3:0]  opcode;
    logic [21:0] imm;

    assign opcode = ir_i[OPC_MSB:OPC_LSB];
    assign imm    = ir_i[IMM_MSB:IMM_LSB];
    assign rd_o   = ir_i[RD_MSB:RD_LSB];
    assign rs1_o  = ir_i[RS1_MSB:RS1_LSB];
    assign rs2_o  = ir_i[RS2_MSB:RS2_LSB];
    assign imm1_o = {{10{imm[21]}}, imm};
    assign imm2_o = {imm[15:0], 16'h0000};

    // Opcode to write-source, ALU operation and sequencing flags.
    always_comb begin
        alu_opcode_o = 2'b00;
        source_o     = SRC_ALU;
        write_o      = 1'b0;
        load_o       = 1'b0;
        jump_o       = 1'b0;
        halt_o       = 1'b0;
        illegal_o    = 1'b0;
        case (opcode)
            OPC_NOP: ;
            OPC_ALU: begin
                write_o      = 1'b1;
                alu_opcode_o = imm[1:0];
            end
            OPC_LDI: begin
                write_o  = 1'b1;
                source_o = SRC_IMM1;
            end
            OPC_LDIH: begin
                write_o  = 1'b1;
                source_o = SRC_IMM2;
            end
            OPC_LOAD: begin
                load_o   = 1'b1;
                source_o = SRC_MEM;
            end
            OPC_JMP:  jump_o = 1'b1;
            OPC_HALT: halt_o = 1'b1;
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Non-pipelined fetch/decode/execute sequencer driving the data path.
//
// state       | meaning
// ------------+------------------------------------------------------------
// START       | one idle cycle after reset before the first fetch
// FETCH       | instruction_request high, wait for instruction_ready
// DECODE      | IR valid, decoded outputs settle
// EXECUTE     | branch on opcode; JMP loads pc here
// WRITEBACK   | output_enable high for one cycle
// MEMORY_WAIT | memory_request high, wait for memory_ready
// HALTED      | terminal until reset; illegal_instruction set if undefined op
module control_unit
    import control_defines::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic        instruction_request,
    output logic [31:0] instruction_address,
    input  logic        instruction_ready,
    input  logic [31:0] instruction_data,
    output logic        memory_request,
    output logic [31:0] memory_address,
    input  logic        memory_ready,
    output logic [1:0]  input_register_selector_1,
    output logic [1:0]  input_register_selector_2,
    output logic [1:0]  output_register_selector,
    output logic [1:0]  output_source_selector,
    output logic        output_enable,
    output logic [1:0]  alu_opcode,
    output logic [31:0] ir_immediate_1,
    output logic [31:0] ir_immediate_2,
    output logic        halted,
    output logic        illegal_instruction
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    logic        ireq_q, mreq_q, oe_q, halted_q;

    logic [31:0] dec_imm1;
    logic        dec_write, dec_load, dec_jump, dec_halt, dec_illegal;

    instruction_decoder u_decoder (
        .ir_i         (ir_q),
        .rd_o         (output_register_selector),
        .rs1_o        (input_register_selector_1),
        .rs2_o        (input_register_selector_2),
        .alu_opcode_o (alu_opcode),
        .source_o     (output_source_selector),
        .imm1_o       (dec_imm1),
        .imm2_o       (ir_immediate_2),
        .write_o      (dec_write),
        .load_o       (dec_load),
        .jump_o       (dec_jump),
        .halt_o       (dec_halt),
        .illegal_o    (dec_illegal)
    );

    // State, PC, IR and the registered strobes; strobes are decoded from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_START;
            pc_q      <= RESET_VECTOR;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            ireq_q    <= 1'b0;
            mreq_q    <= 1'b0;
            oe_q      <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            ireq_q    <= (state_d == ST_FETCH);
            mreq_q    <= (state_d == ST_MEMORY_WAIT);
            oe_q      <= (state_d == ST_WRITEBACK);
            halted_q  <= (state_d == ST_HALTED);
        end
    end

    // Next-state, PC and IR update logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_START: state_d = ST_FETCH;
            ST_FETCH: begin
                if (instruction_ready) begin
                    ir_d    = instruction_data;
                    pc_d    = pc_q + 32'd1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALTED;
                end else if (dec_halt) begin
                    state_d = ST_HALTED;
                end else if (dec_load) begin
                    state_d = ST_MEMORY_WAIT;
                end else if (dec_write) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    if (dec_jump) begin
                        pc_d = dec_imm1;
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_MEMORY_WAIT: begin
                if (memory_ready) begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALTED:    state_d = ST_HALTED;
            default:      state_d = ST_START;
        endcase
    end

    assign instruction_request = ireq_q;
    assign instruction_address = pc_q;
    assign memory_request      = mreq_q;
    assign memory_address      = dec_imm1;
    assign ir_immediate_1      = dec_imm1;
    assign output_enable       = oe_q;
    assign halted              = halted_q;
    assign illegal_instruction = illegal_q;

endmodule
